cache_ctrl: RTL and testbench

- FSM that sequences the 8-set x 256-bit line data array for a direct-mapped, write-back, write-allocate cache.
- Owns tag, valid and dirty state. Decodes CPU word requests into hit or miss.
- Drives the data array's per-byte write enables, index and input select. Runs line writeback and fill transactions on the memory side.
- Sits between the CPU memory port and the line-granular memory/arbiter port.

---
 rtl/cache_pkg.sv | 25 ++
 rtl/cache_ctrl_if.sv | 26 ++
 rtl/cache_ctrl_tag_array.sv | 24 ++
 rtl/cache_ctrl.sv | 122 ++++++++++++
 tb/tb_cache_ctrl.sv | 258 +++++++++++++++++++++++++
 5 files changed

// File: rtl/cache_pkg.sv
// Shared types, geometry and helpers for the direct-mapped write-back cache controller.
// Address layout: tag = addr[31:8], idx = addr[7:5], word = addr[4:2].
package cache_pkg;

   localparam int IDX_W      = 3;
   localparam int OFF_W      = 5;
   localparam int TAG_W      = 32 - IDX_W - OFF_W;
   localparam int NUM_SETS   = 8;
   localparam int LINE_BYTES = 32;
   localparam int WORD_W     = OFF_W - 2;

   typedef enum logic [1:0] {
      IDLE,
      CHECK,
      WRITEBACK,
      FILL
   } cache_state_e;

   // Places the 4 byte enables of a CPU word into its 4-byte slot of the 32-byte line.
   function automatic logic [LINE_BYTES-1:0] mbe_to_we(input logic [3:0]        mbe,
                                                        input logic [WORD_W-1:0] word);
      return {28'b0, mbe} << {word, 2'b00};
   endfunction

endpackage

// File: rtl/cache_ctrl_if.sv
// CPU word port and line-granular memory port of the cache controller.
// master = requester/memory model side, slave = cache_ctrl.
interface cache_ctrl_if;

   logic [31:0] cpu_addr;
   logic        cpu_read;
   logic        cpu_write;
   logic [3:0]  cpu_mbe;
   logic        cpu_resp;

   logic        mem_read;
   logic        mem_write;
   logic [31:0] mem_addr;
   logic        mem_resp;

   modport master (
      output cpu_addr, cpu_read, cpu_write, cpu_mbe, mem_resp,
      input  cpu_resp, mem_read, mem_write, mem_addr
   );

   modport slave (
      input  cpu_addr, cpu_read, cpu_write, cpu_mbe, mem_resp,
      output cpu_resp, mem_read, mem_write, mem_addr
   );

endinterface

// File: rtl/cache_ctrl_tag_array.sv
// Tag register file: one synchronous write port, one combinational read port.
// Contents are meaningful only where the matching valid bit is set.
module tag_array
   import cache_pkg::*;
(
   input  logic             clk,
   input  logic             we,
   input  logic [IDX_W-1:0] widx,
   input  logic [TAG_W-1:0] wdata,
   input  logic [IDX_W-1:0] ridx,
   output logic [TAG_W-1:0] rdata
);

   logic [TAG_W-1:0] tags [NUM_SETS];

   // NOTE: storage is deliberately not reset; the valid vector in the controller
   // masks stale tags, so a reset here would only add cost.
   always_ff @(posedge clk) begin
      if (we) tags[widx] <= wdata;
   end

   assign rdata = tags[ridx];

endmodule

// File: rtl/cache_ctrl.sv
// Direct-mapped, write-back, write-allocate cache controller: hit/miss decode,
// tag/valid/dirty ownership, data-array control and line writeback/fill sequencing.
module cache_ctrl
   import cache_pkg::*;
(
   input  logic                  clk,
   input  logic                  rst_n,
   cache_ctrl_if.slave           bus,
   output logic [LINE_BYTES-1:0] data_we,
   output logic [IDX_W-1:0]      data_index,
   output logic                  data_sel,
   output logic                  hit
);

   cache_state_e state, state_n;

   logic [TAG_W-1:0]    req_tag;
   logic [IDX_W-1:0]    idx;
   logic [WORD_W-1:0]   word;
   logic                addr_unused;

   logic [TAG_W-1:0]    tag_rd;
   logic [NUM_SETS-1:0] valid, dirty;
   logic                tag_we, set_valid, set_dirty, clr_dirty;

   assign req_tag     = bus.cpu_addr[31 -: TAG_W];
   assign idx         = bus.cpu_addr[OFF_W +: IDX_W];
   assign word        = bus.cpu_addr[OFF_W-1:2];
   assign addr_unused = ^bus.cpu_addr[1:0];

   assign data_index  = idx;
   assign hit         = valid[idx] && (tag_rd == req_tag);

   tag_array u_tags (
      .clk   (clk),
      .we    (tag_we),
      .widx  (idx),
      .wdata (req_tag),
      .ridx  (idx),
      .rdata (tag_rd)
   );

   // NOTE: sequential state uses non-blocking assignments so every flop samples
   // the pre-edge values; the combinational process below uses blocking ones.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= IDLE;
      else        state <= state_n;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         valid <= '0;
         dirty <= '0;
      end else begin
         if (set_valid) valid[idx] <= 1'b1;
         if (clr_dirty)      dirty[idx] <= 1'b0;
         else if (set_dirty) dirty[idx] <= 1'b1;
      end
   end

   // NOTE: every output of this process gets a default first, so no path can infer a latch.
   always_comb begin
      state_n       = state;
      bus.cpu_resp  = 1'b0;
      bus.mem_read  = 1'b0;
      bus.mem_write = 1'b0;
      bus.mem_addr  = '0;
      data_we       = '0;
      data_sel      = 1'b0;
      tag_we        = 1'b0;
      set_valid     = 1'b0;
      set_dirty     = 1'b0;
      clr_dirty     = 1'b0;

      unique case (state)
         IDLE: begin
            if (bus.cpu_read || bus.cpu_write) state_n = CHECK;
         end

         CHECK: begin
            if (hit) begin
               bus.cpu_resp = 1'b1;
               state_n      = IDLE;
               // A simultaneous read+write is serviced as a write.
               if (bus.cpu_write) begin
                  data_we   = mbe_to_we(bus.cpu_mbe, word);
                  set_dirty = 1'b1;
               end
            end else if (valid[idx] && dirty[idx]) begin
               state_n = WRITEBACK;
            end else begin
               state_n = FILL;
            end
         end

         WRITEBACK: begin
            bus.mem_write = 1'b1;
            bus.mem_addr  = {tag_rd, idx, {OFF_W{1'b0}}};
            if (bus.mem_resp) begin
               clr_dirty = 1'b1;
               state_n   = FILL;
            end
         end

         FILL: begin
            bus.mem_read = 1'b1;
            bus.mem_addr = {req_tag, idx, {OFF_W{1'b0}}};
            if (bus.mem_resp) begin
               data_we   = '1;
               data_sel  = 1'b1;
               tag_we    = 1'b1;
               set_valid = 1'b1;
               clr_dirty = 1'b1;
               state_n   = CHECK;
            end
         end

         default: state_n = IDLE;
      endcase
   end

endmodule

// File: tb/tb_cache_ctrl.sv
// Scoreboard bench for cache_ctrl: directed accesses push expected output events,
// a negedge monitor pops and compares them whenever the controller presents one.
module tb_cache_ctrl;
   import cache_pkg::*;

   logic                  clk = 1'b0;
   logic                  rst_n = 1'b0;
   logic [LINE_BYTES-1:0] data_we;
   logic [IDX_W-1:0]      data_index;
   logic                  data_sel;
   logic                  hit;

   cache_ctrl_if bus();

   cache_ctrl dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .bus        (bus),
      .data_we    (data_we),
      .data_index (data_index),
      .data_sel   (data_sel),
      .hit        (hit)
   );

   always #5 clk = ~clk;

   typedef struct packed {
      logic        cpu_resp;
      logic        mem_read;
      logic        mem_write;
      logic [31:0] mem_addr;
      logic [31:0] data_we;
      logic        data_sel;
      logic        hit;
      logic [2:0]  index;
   } obs_t;

   obs_t exp_q[$];
   int   checks = 0;
   int   errors = 0;
   int   mem_lat = 0;
   logic resp_auto = 1'b0;
   logic resp_man  = 1'b0;

   assign bus.mem_resp = resp_auto | resp_man;

   function automatic obs_t mk(input logic resp, input logic rd, input logic wr,
                               input logic [31:0] ma, input logic [31:0] we,
                               input logic sel, input logic h, input logic [2:0] ix);
      obs_t o;
      o = '{cpu_resp: resp, mem_read: rd, mem_write: wr, mem_addr: ma,
            data_we: we, data_sel: sel, hit: h, index: ix};
      return o;
   endfunction

   task automatic check(input string name, input logic [79:0] act, input logic [79:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%h expected=%h", name, act, exp);
      end
   endtask

   // Monitor: an event is a cpu_resp, a rising mem_read/mem_write, or any data write.
   initial begin
      logic prev_rd, prev_wr;
      obs_t act, exp;
      prev_rd = 1'b0;
      prev_wr = 1'b0;
      forever begin
         @(negedge clk);
         if (rst_n && (bus.cpu_resp || (bus.mem_read && !prev_rd) ||
                       (bus.mem_write && !prev_wr) || data_we != '0)) begin
            act = mk(bus.cpu_resp, bus.mem_read, bus.mem_write, bus.mem_addr,
                     data_we, data_sel, hit, data_index);
            if (exp_q.size() == 0) begin
               checks++;
               errors++;
               $display("FAIL spurious_event actual=%h expected=none", act);
            end else begin
               exp = exp_q.pop_front();
               check("event", 80'(act), 80'(exp));
            end
         end
         prev_rd = bus.mem_read;
         prev_wr = bus.mem_write;
      end
   end

   // Memory model: mem_resp in cycle mem_lat+1 of each held request.
   initial begin
      int wcnt;
      wcnt = 0;
      forever begin
         @(posedge clk);
         #1;
         if (rst_n && (bus.mem_read || bus.mem_write)) begin
            if (wcnt == mem_lat) begin
               resp_auto = 1'b1;
               wcnt      = 0;
            end else begin
               resp_auto = 1'b0;
               wcnt++;
            end
         end else begin
            resp_auto = 1'b0;
            wcnt      = 0;
         end
      end
   end

   task automatic access(input logic [31:0] addr, input logic rd, input logic wr,
                         input logic [3:0] mbe, input int exp_lat, input string name);
      int cyc;
      bit done;
      cyc  = 0;
      done = 1'b0;
      @(posedge clk);
      #1;
      bus.cpu_addr  = addr;
      bus.cpu_read  = rd;
      bus.cpu_write = wr;
      bus.cpu_mbe   = mbe;
      while (!done && cyc < 200) begin
         @(negedge clk);
         cyc++;
         if (bus.cpu_resp) done = 1'b1;
      end
      if (!done) begin
         checks++;
         errors++;
         $display("FAIL %s_timeout actual=no_resp expected=resp_in_%0d", name, exp_lat);
      end else begin
         check({name, "_latency"}, 80'(cyc), 80'(exp_lat));
      end
      @(posedge clk);
      #1;
      bus.cpu_read  = 1'b0;
      bus.cpu_write = 1'b0;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog actual=running expected=finished");
      $fatal(1, "watchdog expired");
   end

   initial begin
      bus.cpu_addr  = '0;
      bus.cpu_read  = 1'b0;
      bus.cpu_write = 1'b0;
      bus.cpu_mbe   = '0;

      repeat (3) @(posedge clk);
      @(negedge clk);
      check("rst_cpu_resp",  80'(bus.cpu_resp),  80'(0));
      check("rst_mem_read",  80'(bus.mem_read),  80'(0));
      check("rst_mem_write", 80'(bus.mem_write), 80'(0));
      check("rst_mem_addr",  80'(bus.mem_addr),  80'(0));
      check("rst_data_we",   80'(data_we),       80'(0));
      check("rst_data_sel",  80'(data_sel),      80'(0));
      check("rst_hit",       80'(hit),           80'(0));
      @(posedge clk);
      #1;
      rst_n = 1'b1;

      // Clean read miss, memory answers in the 4th request cycle.
      mem_lat = 3;
      exp_q.push_back(mk(0, 1, 0, 32'h0000_0040, 32'h0, 0, 0, 3'd2));
      exp_q.push_back(mk(0, 1, 0, 32'h0000_0040, 32'hFFFF_FFFF, 1, 0, 3'd2));
      exp_q.push_back(mk(1, 0, 0, 32'h0, 32'h0, 0, 1, 3'd2));
      access(32'h0000_0040, 1, 0, 4'h0, 7, "rd_miss_clean");

      // Write hit, word 2, low two bytes.
      exp_q.push_back(mk(1, 0, 0, 32'h0, 32'h0000_0300, 0, 1, 3'd2));
      access(32'h0000_0048, 0, 1, 4'b0011, 2, "wr_hit");

      // Conflicting read on the dirty line: writeback of old tag, then fill.
      mem_lat = 2;
      exp_q.push_back(mk(0, 0, 1, 32'h0000_0040, 32'h0, 0, 0, 3'd2));
      exp_q.push_back(mk(0, 1, 0, 32'h0001_0040, 32'h0, 0, 0, 3'd2));
      exp_q.push_back(mk(0, 1, 0, 32'h0001_0040, 32'hFFFF_FFFF, 1, 0, 3'd2));
      exp_q.push_back(mk(1, 0, 0, 32'h0, 32'h0, 0, 1, 3'd2));
      access(32'h0001_0040, 1, 0, 4'h0, 9, "rd_miss_dirty");

      // Stray mem_resp in IDLE must be ignored; the following hit keeps 2-cycle latency.
      @(posedge clk);
      #1;
      resp_man = 1'b1;
      @(posedge clk);
      #1;
      resp_man = 1'b0;
      exp_q.push_back(mk(1, 0, 0, 32'h0, 32'h0, 0, 1, 3'd2));
      access(32'h0001_0040, 1, 0, 4'h0, 2, "idle_resp_then_hit");

      // Line refilled after writeback is clean: a conflict goes straight to FILL.
      mem_lat = 1;
      exp_q.push_back(mk(0, 1, 0, 32'h0000_0040, 32'h0, 0, 0, 3'd2));
      exp_q.push_back(mk(0, 1, 0, 32'h0000_0040, 32'hFFFF_FFFF, 1, 0, 3'd2));
      exp_q.push_back(mk(1, 0, 0, 32'h0, 32'h0, 0, 1, 3'd2));
      access(32'h0000_0040, 1, 0, 4'h0, 5, "clean_after_wb");

      // mem_resp in the first FILL cycle completes the fill at once.
      mem_lat = 0;
      exp_q.push_back(mk(0, 1, 0, 32'h0000_0060, 32'hFFFF_FFFF, 1, 0, 3'd3));
      exp_q.push_back(mk(1, 0, 0, 32'h0, 32'h0, 0, 1, 3'd3));
      access(32'h0000_0060, 1, 0, 4'h0, 4, "fill_first_cycle_resp");

      // Dirty set 3, then reset in the middle of its writeback.
      exp_q.push_back(mk(1, 0, 0, 32'h0, 32'h0000_00F0, 0, 1, 3'd3));
      access(32'h0000_0064, 0, 1, 4'hF, 2, "wr_hit_word1");

      mem_lat = 20;
      exp_q.push_back(mk(0, 0, 1, 32'h0000_0060, 32'h0, 0, 0, 3'd3));
      @(posedge clk);
      #1;
      bus.cpu_addr = 32'h0002_0060;
      bus.cpu_read = 1'b1;
      repeat (4) @(negedge clk);
      check("wb_in_progress", 80'(bus.mem_write), 80'(1));
      #1;
      rst_n = 1'b0;
      #1;
      check("rst_async_mem_write", 80'(bus.mem_write), 80'(0));
      check("rst_async_mem_read",  80'(bus.mem_read),  80'(0));
      bus.cpu_read = 1'b0;
      @(negedge clk);
      check("rst_held_cpu_resp", 80'(bus.cpu_resp), 80'(0));
      @(posedge clk);
      #1;
      rst_n = 1'b1;

      // All lines invalid after reset: same address fills without a writeback.
      mem_lat = 1;
      exp_q.push_back(mk(0, 1, 0, 32'h0002_0060, 32'h0, 0, 0, 3'd3));
      exp_q.push_back(mk(0, 1, 0, 32'h0002_0060, 32'hFFFF_FFFF, 1, 0, 3'd3));
      exp_q.push_back(mk(1, 0, 0, 32'h0, 32'h0, 0, 1, 3'd3));
      access(32'h0002_0060, 1, 0, 4'h0, 5, "reread_after_rst");

      // Read and write together behave as a write to word 7.
      exp_q.push_back(mk(1, 0, 0, 32'h0, 32'hF000_0000, 0, 1, 3'd3));
      access(32'h0002_007C, 1, 1, 4'hF, 2, "rw_both_word7");

      // That write left the line dirty: a conflict writes it back first.
      exp_q.push_back(mk(0, 0, 1, 32'h0002_0060, 32'h0, 0, 0, 3'd3));
      exp_q.push_back(mk(0, 1, 0, 32'h0000_0060, 32'h0, 0, 0, 3'd3));
      exp_q.push_back(mk(0, 1, 0, 32'h0000_0060, 32'hFFFF_FFFF, 1, 0, 3'd3));
      exp_q.push_back(mk(1, 0, 0, 32'h0, 32'h0, 0, 1, 3'd3));
      access(32'h0000_0060, 1, 0, 4'h0, 7, "dirty_after_rw");

      repeat (3) @(posedge clk);
      check("queue_drained", 80'(exp_q.size()), 80'(0));

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
